// File: rtl/fb_tile_packer.sv
// rtl/fb_tile_packer.sv - packs 16x16 8-bit pixel tiles into 2048-bit frame-buffer words
// Walks tiles left-to-right, top-to-bottom and strobes each packed tile to the write port.
module fb_tile_packer #(
  parameter int TILES_X = 40,
  parameter int TILES_Y = 30
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic          i_pix_valid,
  input  logic [7:0]    i_pix_color,
  output logic          o_pix_ready,
  output logic          o_render_done,
  output logic [5:0]    o_tile_x,
  output logic [5:0]    o_tile_y,
  output logic [2047:0] o_color_data,
  output logic          o_busy,
  output logic          o_frame_done
);

  localparam logic [5:0] LAST_X = 6'(TILES_X - 1);
  localparam logic [5:0] LAST_Y = 6'(TILES_Y - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t     state;
  logic [7:0] pix_cnt;
  logic       hs;

  // o_pix_ready is high exactly while in FILL, so it doubles as the handshake qualifier
  assign hs = i_pix_valid & o_pix_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      pix_cnt       <= 8'd0;
      o_pix_ready   <= 1'b0;
      o_render_done <= 1'b0;
      o_tile_x      <= 6'd0;
      o_tile_y      <= 6'd0;
      o_color_data  <= '0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state       <= FILL;
            o_pix_ready <= 1'b1;
            o_busy      <= 1'b1;
            o_tile_x    <= 6'd0;
            o_tile_y    <= 6'd0;
            pix_cnt     <= 8'd0;
          end
        end
        FILL: begin
          if (hs) begin
            // first pixel shifts up to [2047:2040], last lands in [7:0]
            o_color_data <= {o_color_data[2039:0], i_pix_color};
            pix_cnt      <= pix_cnt + 8'd1;
            if (pix_cnt == 8'd255) begin
              state         <= WRITE;
              o_pix_ready   <= 1'b0;
              o_render_done <= 1'b1;
            end
          end
        end
        WRITE: begin
          o_render_done <= 1'b0;
          pix_cnt       <= 8'd0;
          if (o_tile_x == LAST_X && o_tile_y == LAST_Y) begin
            state        <= DONE;
            o_frame_done <= 1'b1;
          end else begin
            state       <= FILL;
            o_pix_ready <= 1'b1;
            if (o_tile_x == LAST_X) begin
              o_tile_x <= 6'd0;
              o_tile_y <= o_tile_y + 6'd1;
            end else begin
              o_tile_x <= o_tile_x + 6'd1;
            end
          end
        end
        DONE: begin
          o_frame_done <= 1'b0;
          o_busy       <= 1'b0;
          o_tile_x     <= 6'd0;
          o_tile_y     <= 6'd0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
